// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: funct3 access codes, FSM state,
// and the decode helpers used by the top-level request path.
package dmem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} dmem_state_e;

  // Misaligned halves/words and the three unused funct3 codes are all faults.
  function automatic logic is_fault(input logic [2:0] f3, input logic [1:0] alo);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return alo[0];
      F3_LW:         return alo != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] alo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << alo;
      2'b01:   return alo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load formatter: picks the byte/half addressed by a[1:0] out of the
// read word and sign- or zero-extends it according to funct3.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_alo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_alo +: 8];
  assign w_half = i_alo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'b0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'b0, w_half};
      default: o_data = i_word;
    endcase
  end
endmodule

// File: rtl/dmem_byte_lane.sv
// Single-port data memory built from four byte lanes, with power-on zero fill,
// one-cycle response latency and fault reporting for misaligned/illegal accesses.
module dmem_byte_lane
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        rsp_valid,
  output logic [31:0] rd,
  output logic        fault,
  output logic        init_done
);
  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e     r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_init_done, r_rsp_valid, r_fault, r_is_load;
  logic [1:0]      r_alo;
  logic [2:0]      r_f3;
  logic [3:0][7:0] r_rword;

  logic            w_acc, w_fault, w_clr;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_ext;
  logic            w_unused;

  assign req_ready = (r_state == ST_READY);
  assign w_acc     = req_valid & req_ready;
  assign w_fault   = is_fault(funct3, a[1:0]);
  assign w_clr     = (r_state == ST_CLEAR);
  // Upper address bits are deliberately dropped so accesses wrap.
  assign w_idx     = w_clr ? r_cnt : a[AW+1:2];
  assign w_unused  = ^a[31:AW+2];

  always_comb begin
    w_be = 4'h0;
    if (!reset) begin
      if (w_clr)                          w_be = 4'hF;
      else if (w_acc && we && !w_fault)   w_be = byte_en(funct3, a[1:0]);
    end
  end

  always_comb begin
    w_wdata = wd;
    if (w_clr)                     w_wdata = '0;
    else if (funct3[1:0] == 2'b00) w_wdata = {4{wd[7:0]}};
    else if (funct3[1:0] == 2'b01) w_wdata = {2{wd[15:0]}};
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      if (w_be[l]) r_mem[w_idx] <= w_wdata[8*l +: 8];
      r_rword[l] <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (w_clr) begin
      if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
        r_state     <= ST_READY;
        r_init_done <= 1'b1;
      end
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_is_load   <= 1'b0;
      r_alo       <= 2'b00;
      r_f3        <= 3'b000;
    end else begin
      r_rsp_valid <= w_acc;
      if (w_acc) begin
        r_fault   <= w_fault;
        r_is_load <= ~we;
        r_alo     <= a[1:0];
        r_f3      <= funct3;
      end
    end
  end

  dmem_load_ext u_ext (
    .i_word   (r_rword),
    .i_alo    (r_alo),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  assign rsp_valid = r_rsp_valid;
  assign fault     = r_rsp_valid & r_fault;
  assign rd        = (r_rsp_valid && r_is_load && !r_fault) ? w_ext : '0;
  assign init_done = r_init_done;
endmodule

// File: tb/tb_dmem_byte_lane.sv
// Bench for dmem_byte_lane: byte-array reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_dmem_byte_lane;
  import dmem_pkg::*;
  localparam int DEPTH = 256;

  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0, wd = '0;
  logic        req_ready, rsp_valid, fault, init_done;
  logic [31:0] rd;
  int checks = 0, errors = 0;

  dmem_byte_lane #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .funct3(funct3), .a(a), .wd(wd), .rsp_valid(rsp_valid),
    .rd(rd), .fault(fault), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array, readiness counted in cycles since reset.
  logic [7:0]  m_mem [4*DEPTH];
  int          m_clr;
  bit          m_ready, m_vld, m_fault;
  logic [31:0] m_rd;

  task automatic model_req();
    int n, base;
    logic [31:0] v;
    n    = (funct3[1:0] == 2'd0) ? 1 : (funct3[1:0] == 2'd1) ? 2 : 4;
    base = int'(a % 32'(4*DEPTH));
    m_vld = 1'b1;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 || (base % n) != 0)
      m_fault = 1'b1;
    else if (we) begin
      for (int i = 0; i < n; i++) m_mem[base+i] = 8'(wd >> (8*i));
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(m_mem[base+i]) << (8*i));
      if (!funct3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      m_rd = v;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clr = 0; m_ready = 1'b0; m_vld = 1'b0; m_fault = 1'b0; m_rd = '0;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
    end else begin
      m_vld = 1'b0; m_fault = 1'b0; m_rd = '0;
      if (!m_ready) begin
        m_clr++;
        m_ready = (m_clr == DEPTH);
      end else if (req_valid) model_req();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("init_done", 32'(init_done), 32'(m_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      chk("fault",     32'(fault),     32'(m_fault));
      chk("rd",        rd,             m_rd);
    end
  end

  task automatic req(input bit w, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] d);
    req_valid = 1'b1; we = w; funct3 = f; a = ad; wd = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] exp_rd, input bit exp_f);
    chk({nm, "_vld"},   32'(rsp_valid), 32'd1);
    chk({nm, "_rd"},    rd,             exp_rd);
    chk({nm, "_fault"}, 32'(fault),     32'(exp_f));
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic reset_outs(input string nm);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_fault"},     32'(fault),     32'd0);
    chk({nm, "_rd"},        rd,             32'd0);
    chk({nm, "_init_done"}, 32'(init_done), 32'd0);
    chk({nm, "_ready"},     32'(req_ready), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    #1 reset_outs("reset");
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    chk("clear_cycles", 32'(n), 32'd256);
    chk("ready_after_clear", 32'(req_ready), 32'd1);

    req(1'b0, F3_LW, 32'h3FC, 0);          lit("lw_3fc_zero", 32'h0, 1'b0);
    req(1'b1, F3_LW, 32'h4, 32'hAA55AA55);
    req(1'b1, F3_LB, 32'h5, 32'h000000FF); lit("sb_resp", 32'h0, 1'b0);
    req(1'b0, F3_LW, 32'h4, 0);            lit("lw_4", 32'hAA55FF55, 1'b0);
    req(1'b0, F3_LB, 32'h5, 0);            lit("lb_5", 32'hFFFFFFFF, 1'b0);
    req(1'b0, F3_LBU, 32'h5, 0);           lit("lbu_5", 32'h000000FF, 1'b0);
    req(1'b0, F3_LH, 32'h6, 0);            lit("lh_6", 32'hFFFFAA55, 1'b0);
    req(1'b0, F3_LHU, 32'h6, 0);           lit("lhu_6", 32'h0000AA55, 1'b0);
    req(1'b1, F3_LW, 32'h8, 32'h12345678);
    req(1'b0, F3_LW, 32'h9, 0);            lit("lw_9_mis", 32'h0, 1'b1);
    req(1'b1, F3_LH, 32'hB, 32'hFFFF);     lit("sh_b_mis", 32'h0, 1'b1);
    req(1'b0, F3_LW, 32'h8, 0);            lit("lw_8", 32'h12345678, 1'b0);
    req(1'b0, 3'b011, 32'h8, 0);           lit("f3_011", 32'h0, 1'b1);
    req(1'b1, F3_LW, 32'h400, 32'hDEADBEEF);
    req(1'b0, F3_LW, 32'h0, 0);            lit("wrap_wf", 32'hDEADBEEF, 1'b0);
    req(1'b1, F3_LB, 32'h403, 32'h77);
    req(1'b0, F3_LW, 32'h0, 0);            lit("wrap_sb", 32'h77ADBEEF, 1'b0);

    // Back-to-back mixed traffic over a few words, all address aliases included.
    repeat (300) begin
      r = $urandom;
      req_valid = (r[7:5] != 3'd0);
      we = r[0]; funct3 = r[3:1];
      a  = ($urandom_range(0, 3) << 10) | $urandom_range(0, 31);
      wd = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    req(1'b1, F3_LW, 32'h40, 32'h13579BDF);
    req(1'b0, F3_LW, 32'h40, 0);           lit("pend_pre", 32'h13579BDF, 1'b0);
    reset = 1'b1;
    #1 reset_outs("pend_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1 reset_outs("mid_clear_rst");
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    chk("reclear_cycles", 32'(n), 32'd256);
    req(1'b0, F3_LW, 32'h40, 0);           lit("cleared_40", 32'h0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
